// File: rtl/id_ex_hazard_reg_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// id_ex_hazard_reg_pkg : shared widths, control-bundle layout, update kinds
// Rev 1.0
// ------------------------------------------------------------------
package id_ex_hazard_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 16;
  localparam int CTRL_W     = 8;

  // Bit positions inside the opaque EX/MEM/WB control bundle
  localparam int c_ctrl_memwrite  = 0;
  localparam int c_ctrl_memtoreg  = 1;
  localparam int c_ctrl_alusrc    = 2;
  localparam int c_ctrl_aluop_lsb = 3;
  localparam int c_ctrl_aluop_msb = 4;
  localparam int c_ctrl_regdst    = 5;

  localparam logic [CTRL_W-1:0]     c_ctrl_nop = '0;
  localparam logic [REG_AW_DEF-1:0] c_reg_zero = '0;

  typedef enum logic [2:0] {
    UPD_RESET  = 3'd0,
    UPD_FLUSH  = 3'd1,
    UPD_HOLD   = 3'd2,
    UPD_BUBBLE = 3'd3,
    UPD_LOAD   = 3'd4
  } upd_e;

  function automatic upd_e sel_update(input logic rst, input logic flush,
                                      input logic hold, input logic haz);
    upd_e r;
    if (rst)        r = UPD_RESET;
    else if (flush) r = UPD_FLUSH;
    else if (hold)  r = UPD_HOLD;
    else if (haz)   r = UPD_BUBBLE;
    else            r = UPD_LOAD;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_hazard_reg_if.sv
`default_nettype none
// ------------------------------------------------------------------
// id_ex_hazard_if : ID-side inputs and EX-side outputs of the ID/EX register
// Rev 1.0
// ------------------------------------------------------------------
interface id_ex_hazard_if
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              hold_i;
  logic              flush_i;
  logic              id_valid_i;
  logic              id_uses_rt_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic [REG_AW-1:0] id_rd_i;
  logic [DATA_W-1:0] id_rs_data_i;
  logic [DATA_W-1:0] id_rt_data_i;
  logic [DATA_W-1:0] id_imm_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic [CTRL_W-1:0] id_ctrl_i;

  logic              stall_o;
  logic              ex_valid_o;
  logic [REG_AW-1:0] ex_rs_o;
  logic [REG_AW-1:0] ex_rt_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic [DATA_W-1:0] ex_rs_data_o;
  logic [DATA_W-1:0] ex_rt_data_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic              ex_regwrite_o;
  logic              ex_memread_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output hold_i, flush_i, id_valid_i, id_uses_rt_i, id_rs_i, id_rt_i, id_rd_i,
           id_rs_data_i, id_rt_data_i, id_imm_i, id_regwrite_i, id_memread_i, id_ctrl_i,
    input  stall_o, ex_valid_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_rs_data_o, ex_rt_data_o,
           ex_imm_o, ex_regwrite_o, ex_memread_o, ex_ctrl_o, bubble_cnt_o
  );

  modport slave (
    input  hold_i, flush_i, id_valid_i, id_uses_rt_i, id_rs_i, id_rt_i, id_rd_i,
           id_rs_data_i, id_rt_data_i, id_imm_i, id_regwrite_i, id_memread_i, id_ctrl_i,
    output stall_o, ex_valid_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_rs_data_o, ex_rt_data_o,
           ex_imm_o, ex_regwrite_o, ex_memread_o, ex_ctrl_o, bubble_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
`default_nettype none
// ------------------------------------------------------------------
// id_ex_hazard_reg_load_use_detect : load in EX feeding a source of the ID instruction
// Rev 1.0
// ------------------------------------------------------------------
module id_ex_hazard_reg_load_use_detect
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  wire logic              i_ex_valid,
  input  wire logic              i_ex_memread,
  input  wire logic [REG_AW-1:0] i_ex_rt,
  input  wire logic              i_id_valid,
  input  wire logic              i_id_uses_rt,
  input  wire logic [REG_AW-1:0] i_id_rs,
  input  wire logic [REG_AW-1:0] i_id_rt,
  output logic                   o_haz
);
  logic w_rs_match;
  logic w_rt_match;
  logic w_load_live;

  // $zero is never a real producer, so a load targeting it cannot create a dependency
  assign w_load_live = i_ex_valid & i_ex_memread & (i_ex_rt != REG_AW'(c_reg_zero));
  assign w_rs_match  = (i_ex_rt == i_id_rs);
  assign w_rt_match  = i_id_uses_rt & (i_ex_rt == i_id_rt);
  assign o_haz       = w_load_live & i_id_valid & (w_rs_match | w_rt_match);
endmodule
`default_nettype wire

// File: rtl/id_ex_hazard_reg.sv
`default_nettype none
// ------------------------------------------------------------------
// id_ex_hazard_reg : ID/EX pipeline register with load-use bubble insertion
// Rev 1.0
// ------------------------------------------------------------------
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  wire logic      clk_i,
  input  wire logic      rst_i,
  id_ex_hazard_if.slave  bus
);
  logic              r_valid;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic              r_regwrite;
  logic              r_memread;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_haz;
  upd_e w_upd;

  id_ex_hazard_reg_load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .i_ex_valid   (r_valid),
    .i_ex_memread (r_memread),
    .i_ex_rt      (r_rt),
    .i_id_valid   (bus.id_valid_i),
    .i_id_uses_rt (bus.id_uses_rt_i),
    .i_id_rs      (bus.id_rs_i),
    .i_id_rt      (bus.id_rt_i),
    .o_haz        (w_haz)
  );

  assign w_upd = sel_update(rst_i, bus.flush_i, bus.hold_i, w_haz);

  // A flush kills the ID instruction and a hold freezes the front end already
  assign bus.stall_o = w_haz & ~bus.flush_i & ~bus.hold_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    case (w_upd)
      UPD_RESET, UPD_FLUSH, UPD_BUBBLE: begin
        r_valid    <= 1'b0;
        r_rs       <= '0;
        r_rt       <= '0;
        r_rd       <= '0;
        r_rs_data  <= '0;
        r_rt_data  <= '0;
        r_imm      <= '0;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_ctrl     <= c_ctrl_nop;
      end
      UPD_LOAD: begin
        r_valid    <= bus.id_valid_i;
        r_rs       <= bus.id_rs_i;
        r_rt       <= bus.id_rt_i;
        r_rd       <= bus.id_rd_i;
        r_rs_data  <= bus.id_rs_data_i;
        r_rt_data  <= bus.id_rt_data_i;
        r_imm      <= bus.id_imm_i;
        r_regwrite <= bus.id_regwrite_i & bus.id_valid_i;
        r_memread  <= bus.id_memread_i & bus.id_valid_i;
        r_ctrl     <= bus.id_valid_i ? bus.id_ctrl_i : c_ctrl_nop;
      end
      default: ;
    endcase
  end

  // Only load-use bubbles are counted; the counter sticks at all-ones
  always_ff @(posedge clk_i) begin
    if (w_upd == UPD_RESET) begin
      r_bubble_cnt <= '0;
    end else if (w_upd == UPD_BUBBLE && r_bubble_cnt != {CNT_W{1'b1}}) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.ex_valid_o    = r_valid;
  assign bus.ex_rs_o       = r_rs;
  assign bus.ex_rt_o       = r_rt;
  assign bus.ex_rd_o       = r_rd;
  assign bus.ex_rs_data_o  = r_rs_data;
  assign bus.ex_rt_data_o  = r_rt_data;
  assign bus.ex_imm_o      = r_imm;
  assign bus.ex_regwrite_o = r_regwrite;
  assign bus.ex_memread_o  = r_memread;
  assign bus.ex_ctrl_o     = r_ctrl;
  assign bus.bubble_cnt_o  = r_bubble_cnt;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_reg.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_id_ex_hazard_reg : directed bench for the ID/EX hazard register
// Rev 1.0
// ------------------------------------------------------------------
module tb_id_ex_hazard_reg;
  import id_ex_hazard_reg_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  id_ex_hazard_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();
  id_ex_hazard_if #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  bus_s ();

  id_ex_hazard_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Narrow counter instance so saturation is reachable in a few cycles
  id_ex_hazard_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) dut_sat (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic ur,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic rw, input logic mr, input logic [7:0] ctrl);
    bus.id_valid_i    = v;
    bus.id_uses_rt_i  = ur;
    bus.id_rs_i       = rs;
    bus.id_rt_i       = rt;
    bus.id_rd_i       = rd;
    bus.id_rs_data_i  = rsd;
    bus.id_rt_data_i  = rtd;
    bus.id_imm_i      = imm;
    bus.id_regwrite_i = rw;
    bus.id_memread_i  = mr;
    bus.id_ctrl_i     = ctrl;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.hold_i  = 1'b0;
    bus.flush_i = 1'b0;
    drive_id(1'b1, 1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
             $urandom, 1'b1, 1'b1, 8'($urandom));
    bus_s.hold_i = 1'b0; bus_s.flush_i = 1'b0; bus_s.id_valid_i = 1'b0;
    bus_s.id_uses_rt_i = 1'b0; bus_s.id_rs_i = 5'd0; bus_s.id_rt_i = 5'd0;
    bus_s.id_rd_i = 5'd0; bus_s.id_rs_data_i = '0; bus_s.id_rt_data_i = '0;
    bus_s.id_imm_i = '0; bus_s.id_regwrite_i = 1'b0; bus_s.id_memread_i = 1'b0;
    bus_s.id_ctrl_i = 8'h00;

    // 1: reset with live ID inputs
    tick();
    tick();
    chk("rst_valid",    bus.ex_valid_o,    1'b0);
    chk("rst_regwrite", bus.ex_regwrite_o, 1'b0);
    chk("rst_memread",  bus.ex_memread_o,  1'b0);
    chk("rst_ctrl",     bus.ex_ctrl_o,     8'h00);
    chk("rst_rt",       bus.ex_rt_o,       5'd0);
    chk("rst_rs_data",  bus.ex_rs_data_o,  32'h0);
    chk("rst_imm",      bus.ex_imm_o,      32'h0);
    chk("rst_cnt",      bus.bubble_cnt_o,  16'h0);
    chk("rst_stall",    bus.stall_o,       1'b0);
    rst = 1'b0;
    drive_id(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h00);

    // 2: lw $8 then add $9,$8,$1
    drive_id(1'b1, 1'b0, 5'd2, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 8'h06);
    #1 chk("lw_no_stall", bus.stall_o, 1'b0);
    tick();
    chk("lw_ex_valid",   bus.ex_valid_o,   1'b1);
    chk("lw_ex_rt",      bus.ex_rt_o,      5'd8);
    chk("lw_ex_memread", bus.ex_memread_o, 1'b1);
    chk("lw_ex_imm",     bus.ex_imm_o,     32'h4);
    drive_id(1'b1, 1'b1, 5'd8, 5'd1, 5'd9, 32'h11111111, 32'h22222222, 32'h0, 1'b1, 1'b0, 8'h21);
    #1 chk("add_stall", bus.stall_o, 1'b1);
    tick();
    chk("bub_valid",    bus.ex_valid_o,    1'b0);
    chk("bub_regwrite", bus.ex_regwrite_o, 1'b0);
    chk("bub_ctrl",     bus.ex_ctrl_o,     8'h00);
    chk("bub_cnt1",     bus.bubble_cnt_o,  16'd1);
    chk("bub_stall_off", bus.stall_o,      1'b0);
    tick();
    chk("add_valid",    bus.ex_valid_o,    1'b1);
    chk("add_rd",       bus.ex_rd_o,       5'd9);
    chk("add_rs",       bus.ex_rs_o,       5'd8);
    chk("add_rs_data",  bus.ex_rs_data_o,  32'h11111111);
    chk("add_rt_data",  bus.ex_rt_data_o,  32'h22222222);
    chk("add_regwrite", bus.ex_regwrite_o, 1'b1);
    chk("add_memread",  bus.ex_memread_o,  1'b0);
    chk("add_ctrl",     bus.ex_ctrl_o,     8'h21);

    // 3a: lw $0 then add $9,$0,$1 -> no hazard
    drive_id(1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 32'h100, 32'h0, 32'h8, 1'b1, 1'b1, 8'h06);
    tick();
    drive_id(1'b1, 1'b1, 5'd0, 5'd1, 5'd9, 32'h0, 32'h5, 32'h0, 1'b1, 1'b0, 8'h21);
    #1 chk("zero_no_stall", bus.stall_o, 1'b0);
    tick();
    chk("zero_add_valid", bus.ex_valid_o,   1'b1);
    chk("zero_add_rd",    bus.ex_rd_o,      5'd9);
    chk("zero_cnt",       bus.bubble_cnt_o, 16'd1);

    // 3b: lw $5 then sw $5 (rt used as source)
    drive_id(1'b1, 1'b0, 5'd2, 5'd5, 5'd0, 32'h200, 32'h0, 32'hC, 1'b1, 1'b1, 8'h06);
    tick();
    drive_id(1'b1, 1'b1, 5'd3, 5'd5, 5'd0, 32'h300, 32'h55, 32'h10, 1'b0, 1'b0, 8'h05);
    #1 chk("sw_stall", bus.stall_o, 1'b1);
    tick();
    chk("sw_bub_valid", bus.ex_valid_o,   1'b0);
    chk("sw_cnt2",      bus.bubble_cnt_o, 16'd2);
    chk("sw_stall_off", bus.stall_o,      1'b0);
    tick();
    chk("sw_valid", bus.ex_valid_o, 1'b1);
    chk("sw_ctrl",  bus.ex_ctrl_o,  8'h05);

    // 4: hazard coincident with flush
    drive_id(1'b1, 1'b0, 5'd2, 5'd7, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 8'h06);
    tick();
    drive_id(1'b1, 1'b1, 5'd7, 5'd1, 5'd10, 32'hAAAA0000, 32'hBBBB0000, 32'h0, 1'b1, 1'b0, 8'h21);
    bus.flush_i = 1'b1;
    #1 chk("flush_haz_stall", bus.stall_o, 1'b0);
    tick();
    bus.flush_i = 1'b0;
    chk("flush_valid",    bus.ex_valid_o,    1'b0);
    chk("flush_memread",  bus.ex_memread_o,  1'b0);
    chk("flush_cnt_same", bus.bubble_cnt_o,  16'd2);
    tick();
    chk("post_flush_rd", bus.ex_rd_o, 5'd10);

    // 5a: hold freezes EX while ID changes
    bus.hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 1'b0, 5'(20 + i), 5'(21 + i), 5'(22 + i), 32'(i), 32'(i), 32'(i),
               1'b0, 1'b1, 8'h0F);
      tick();
      chk("hold_rd",      bus.ex_rd_o,      5'd10);
      chk("hold_rs_data", bus.ex_rs_data_o, 32'hAAAA0000);
      chk("hold_valid",   bus.ex_valid_o,   1'b1);
    end
    // 5b: flush during hold still bubbles
    bus.flush_i = 1'b1;
    tick();
    chk("hold_flush_valid",    bus.ex_valid_o,    1'b0);
    chk("hold_flush_regwrite", bus.ex_regwrite_o, 1'b0);
    bus.flush_i = 1'b0;
    bus.hold_i  = 1'b0;

    // 5c: hold outranks a pending hazard
    drive_id(1'b1, 1'b0, 5'd2, 5'd6, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 8'h06);
    tick();
    drive_id(1'b1, 1'b0, 5'd6, 5'd2, 5'd11, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h21);
    bus.hold_i = 1'b1;
    #1 chk("hold_haz_stall", bus.stall_o, 1'b0);
    tick();
    chk("hold_haz_memread", bus.ex_memread_o, 1'b1);
    chk("hold_haz_cnt",     bus.bubble_cnt_o, 16'd2);
    bus.hold_i = 1'b0;
    #1 chk("release_stall", bus.stall_o, 1'b1);
    tick();
    chk("release_cnt3", bus.bubble_cnt_o, 16'd3);

    // 6: back-to-back lw $4,0($4) stalls once each; 2-bit counter saturates at 3
    bus_s.id_valid_i    = 1'b1;
    bus_s.id_rs_i       = 5'd4;
    bus_s.id_rt_i       = 5'd4;
    bus_s.id_regwrite_i = 1'b1;
    bus_s.id_memread_i  = 1'b1;
    bus_s.id_ctrl_i     = 8'h06;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("sat_stall", bus_s.stall_o, 1'b1);
      tick();
      chk("sat_cnt", bus_s.bubble_cnt_o, (k > 3) ? 2'd3 : 2'(k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
